// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, step enable and a valid/ready word packer.
// Optional macro LFSR_PERIOD_CNT_EN adds a sequence-period measurement counter.
module lfsr_prbs_gen #(
   parameter int unsigned      WIDTH  = 16,
   parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
   parameter int unsigned      OUT_W  = 8,
   parameter bit               GALOIS = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_n,
   input  logic [WIDTH-1:0] seed,
   input  logic             en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_bit,
   output logic [WIDTH-1:0] state,
   output logic             lockup,
   output logic [WIDTH-1:0] period,
   output logic             period_done
);

   // state | meaning
   // FILL  | collecting bits, LFSR steps on each enabled edge
   // HOLD  | complete word presented, LFSR frozen until out_ready

   typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} fsm_t;

   localparam int unsigned      CNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(OUT_W - 1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_STATE = (SEED == '0) ? ONE : SEED;

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_d;
   logic [OUT_W-1:0] data_d;
   logic [CNT_W-1:0] bit_cnt, cnt_d;
   logic             valid_d;
   logic             lockup_d;
   logic [WIDTH-1:0] fib_next, gal_next, step_next;

   assign fib_next  = {state[WIDTH-2:0], ^(state & TAPS)};
   assign gal_next  = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
   assign step_next = GALOIS ? gal_next : fib_next;

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state;
      data_d   = out_data;
      cnt_d    = bit_cnt;
      valid_d  = out_valid;
      lockup_d = 1'b0;
      if (!load_n) begin
         state_d  = (seed == '0) ? ONE : seed;
         lockup_d = (seed == '0);
         cnt_d    = '0;
         valid_d  = 1'b0;
         data_d   = '0;
         fsm_d    = FILL;
      end else begin
         case (fsm_q)
            FILL: begin
               if (en) begin
                  // a degenerate tap mask must still never reach the all-zero state
                  state_d = (step_next == '0) ? ONE : step_next;
                  data_d  = (out_data << 1) | OUT_W'(state[WIDTH-1]);
                  if (bit_cnt == LAST_BIT) begin
                     cnt_d   = '0;
                     valid_d = 1'b1;
                     fsm_d   = HOLD;
                  end else begin
                     cnt_d = bit_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               valid_d = 1'b1;
               if (out_ready) begin
                  valid_d = 1'b0;
                  fsm_d   = FILL;
               end
            end
            default: fsm_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= FILL;
         state     <= RST_STATE;
         out_data  <= '0;
         bit_cnt   <= '0;
         out_valid <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         state     <= state_d;
         out_data  <= data_d;
         bit_cnt   <= cnt_d;
         out_valid <= valid_d;
         lockup    <= lockup_d;
      end
   end

   assign out_bit = state[WIDTH-1];

`ifdef LFSR_PERIOD_CNT_EN
   logic             step;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] pcnt_q;
   logic [WIDTH-1:0] period_q;
   logic             done_q;

   assign step = load_n && (fsm_q == FILL) && en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q    <= RST_STATE;
         pcnt_q   <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
      end else if (!load_n) begin
         cap_q    <= state_d;
         pcnt_q   <= '0;
         period_q <= '0;
         done_q   <= 1'b0;
      end else if (step && !done_q && (pcnt_q != '1)) begin
         // saturation at all-ones stops counting without declaring a period
         pcnt_q <= pcnt_q + ONE;
         if (state_d == cap_q) begin
            period_q <= pcnt_q + ONE;
            done_q   <= 1'b1;
         end
      end
   end

   assign period      = period_q;
   assign period_done = done_q;
`else
   assign period      = '0;
   assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: 4-bit Fibonacci (taps 1001) and Galois (taps 0011) instances.
module tb_lfsr_prbs_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_n, en, out_ready;
   logic [3:0] seed;
   logic       out_valid, out_bit, lockup, period_done;
   logic [3:0] out_data, state, period;

   logic       g_load_n, g_en, g_ready;
   logic [3:0] g_seed;
   logic       g_valid, g_bit, g_lockup, g_done;
   logic [3:0] g_data, g_state, g_period;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'b0001), .OUT_W(4), .GALOIS(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .load_n(load_n), .seed(seed), .en(en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bit(out_bit),
      .state(state), .lockup(lockup), .period(period), .period_done(period_done));

   lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'b0001), .OUT_W(4), .GALOIS(1'b1)) dut_g (
      .clk(clk), .rst_n(rst_n), .load_n(g_load_n), .seed(g_seed), .en(g_en),
      .out_valid(g_valid), .out_ready(g_ready), .out_data(g_data), .out_bit(g_bit),
      .state(g_state), .lockup(g_lockup), .period(g_period), .period_done(g_done));

`ifdef LFSR_PERIOD_CNT_EN
   localparam logic [3:0] EXP_PERIOD = 4'd15;
   localparam logic       EXP_DONE   = 1'b1;
`else
   localparam logic [3:0] EXP_PERIOD = 4'd0;
   localparam logic       EXP_DONE   = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] fib_seq[4];
      logic [3:0] gal_seq[4];
      fib_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
      gal_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0011};

      rst_n = 1'b0; load_n = 1'b1; en = 1'b0; out_ready = 1'b0; seed = 4'b0000;
      g_load_n = 1'b1; g_en = 1'b0; g_ready = 1'b0; g_seed = 4'b0000;
      #12;
      check("rst_state", state, 4'b0001);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 4'b0000);
      check("rst_lockup", lockup, 1'b0);
      check("rst_period", period, 4'd0);
      check("rst_done", period_done, 1'b0);
      rst_n = 1'b1;

      // first two words and free run back to the seed
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("fill_state", state, fib_seq[i]);
         check("fill_valid", out_valid, (i == 3) ? 1'b1 : 1'b0);
      end
      check("word1", out_data, 4'b0001);
      tick();
      check("release_valid", out_valid, 1'b0);
      check("release_state", state, 4'b1110);
      for (int i = 0; i < 4; i++) tick();
      check("word2_valid", out_valid, 1'b1);
      check("word2", out_data, 4'b1110);
      check("word2_state", state, 4'b1011);
      for (int i = 0; i < 9; i++) tick();
      check("wrap_state", state, 4'b0001);
      check("period", period, EXP_PERIOD);
      check("period_done", period_done, EXP_DONE);

      // backpressure
      load_n = 1'b0; seed = 4'b0001; out_ready = 1'b0;
      tick();
      check("load1_state", state, 4'b0001);
      check("load1_lockup", lockup, 1'b0);
      check("load1_period", period, 4'd0);
      load_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("bp_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_data", out_data, 4'b0001);
         check("bp_hold_state", state, 4'b1110);
      end
      out_ready = 1'b1;
      tick();
      check("bp_fall", out_valid, 1'b0);
      check("bp_nostep", state, 4'b1110);
      tick();
      check("bp_resume", state, 4'b1101);

      // zero seed lockup mid-fill
      load_n = 1'b0; seed = 4'b0000;
      tick();
      check("lock_state", state, 4'b0001);
      check("lock_pulse", lockup, 1'b1);
      check("lock_valid", out_valid, 1'b0);
      check("lock_data", out_data, 4'b0000);
      load_n = 1'b1; en = 1'b0;
      tick();
      check("lock_clear", lockup, 1'b0);
      check("lock_hold_state", state, 4'b0001);
      en = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("lock_cnt_early", out_valid, 1'b0);
      tick();
      check("lock_cnt_word", out_valid, 1'b1);
      check("lock_word", out_data, 4'b0001);
      load_n = 1'b0; seed = 4'b1010;
      tick();
      check("seed_state", state, 4'b1010);
      check("seed_lockup", lockup, 1'b0);
      check("seed_valid", out_valid, 1'b0);
      load_n = 1'b1;

      // enable gating with two bits collected
      tick();
      tick();
      check("gate_pre", state, 4'b1011);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("gate_state", state, 4'b1011);
         check("gate_valid", out_valid, 1'b0);
      end
      en = 1'b1;
      tick();
      check("gate_step3", state, 4'b0110);
      check("gate_step3_valid", out_valid, 1'b0);
      tick();
      check("gate_word_valid", out_valid, 1'b1);
      check("gate_word", out_data, 4'b1010);
      check("gate_word_state", state, 4'b1100);

      // asynchronous reset while holding
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_state", state, 4'b0001);
      check("arst_data", out_data, 4'b0000);
      #2 rst_n = 1'b1;
      en = 1'b0;
      tick();
      check("arst_after", state, 4'b0001);

      // Galois structure
      g_load_n = 1'b0; g_seed = 4'b0001;
      tick();
      check("g_load", g_state, 4'b0001);
      g_load_n = 1'b1; g_en = 1'b1; g_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("g_state", g_state, gal_seq[i]);
      end
      check("g_valid", g_valid, 1'b1);
      check("g_word", g_data, 4'b0001);
      for (int i = 0; i < 14; i++) tick();
      check("g_wrap", g_state, 4'b0001);
      check("g_period", g_period, EXP_PERIOD);
      check("g_done", g_done, EXP_DONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
